// File: rtl/signature_compactor.sv
// +----------------------------------------------------------------------------+
// | signature_compactor: up-counting stimulus generator + response compactor   |
// | Optional macro SIG_COMPARE_EN adds expected_sig / pass / fail.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module signature_compactor #(
  parameter int DATA_W  = 8,
  parameter int STIM_W  = 8,
  parameter int ROT_AMT = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_W-1:0]     seed,
  input  logic [DATA_W-1:0]     dut_resp,
`ifdef SIG_COMPARE_EN
  input  logic [2*DATA_W-1:0]   expected_sig,
  output logic                  pass,
  output logic                  fail,
`endif
  output logic [STIM_W-1:0]     stimulus,
  output logic [2*DATA_W-1:0]   signature,
  output logic                  busy,
  output logic                  done
);

  localparam int SIG_W = 2 * DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [DATA_W-1:0] seed_q, seed_d;

  logic              w_accept;
  logic              w_last;
  logic [DATA_W-1:0] w_scr;
  logic [DATA_W-1:0] w_sum;
  logic [SIG_W-1:0]  w_cat;
  logic [SIG_W-1:0]  w_next;

  assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_last   = &stim_q;

  assign w_scr  = seed_q ^ dut_resp;
  assign w_sum  = sig_q[DATA_W-1:0] + w_scr;
  assign w_cat  = {sig_q[SIG_W-1:DATA_W], w_sum};
  assign w_next = (w_cat << ROT_AMT) | (w_cat >> (SIG_W - ROT_AMT));

  // State register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (w_last) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    stim_d = stim_q;
    sig_d  = sig_q;
    seed_d = seed_q;
    if (w_accept) begin
      stim_d = '0;
      sig_d  = '0;
      seed_d = seed;
    end else if ((state_q == S_RUN) && !w_last) begin
      // The response to the all-ones stimulus is deliberately never folded in.
      stim_d = stim_q + 1'b1;
      sig_d  = w_next;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      stim_q <= '0;
      sig_q  <= '0;
      seed_q <= '0;
    end else begin
      stim_q <= stim_d;
      sig_q  <= sig_d;
      seed_q <= seed_d;
    end
  end

  assign stimulus  = stim_q;
  assign signature = sig_q;

`ifdef SIG_COMPARE_EN
  logic pass_q, pass_d;
  logic fail_q, fail_d;
  logic w_match;

  assign w_match = (sig_q == expected_sig);

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (w_accept) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else if ((state_q == S_RUN) && w_last) begin
      pass_d = w_match;
      fail_d = !w_match;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

`default_nettype wire
